// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
//   Shared helpers for the async FIFO pointer logic.
//
//   The helpers work on a fixed-width word (MAX_PTR_W bits). A caller widens a
//   narrower pointer with zero-extension before the call and truncates the
//   result back. Leading zeros do not change a gray/binary conversion or a
//   popcount, so one set of functions serves every ADDRSIZE up to
//   MAX_PTR_W-1.
//
//   Contents:
//     MIN_SYNC_STAGES / MAX_SYNC_STAGES : legal synchroniser depth range
//     MAX_PTR_W                         : widest pointer the helpers handle
//     gray2bin(g)                       : gray code -> binary
//     bin2gray(b)                       : binary -> gray code
//     popcount(v)                       : number of set bits
// ----------------------------------------------------------------------------
package fifo_pkg;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;
    localparam int MAX_PTR_W       = 32;

    typedef logic [MAX_PTR_W-1:0] ptr_word_t;

    // Binary bit i is the XOR of gray bits i and above. The shift-doubling
    // loop builds that suffix-XOR in log2(MAX_PTR_W) steps.
    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = g;
        for (int s = 1; s < MAX_PTR_W; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic int unsigned popcount(input ptr_word_t v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_PTR_W; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage : fifo_pkg

// File: rtl/sync_ff_chain.sv
// ----------------------------------------------------------------------------
// sync_ff_chain
//   Plain multi-flop synchroniser. Only stage 0 samples the asynchronous
//   input, and no logic sits between stages, so each flop gets the full clock
//   period to resolve metastability. Usable for multi-bit gray buses, where
//   at most one bit changes at a time, and for single-bit control signals.
//
//   Parameters:
//     WIDTH  : bus width
//     STAGES : number of flops in the chain (>= 1)
//
//   Ports:
//     clk    in   receiving-domain clock
//     rst_n  in   asynchronous active-low reset; clears every stage
//     d      in   WIDTH  asynchronous input
//     q      out  WIDTH  output of the last stage
// ----------------------------------------------------------------------------
module sync_ff_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (STAGES < 1) begin : g_bad_stages
        $error("sync_ff_chain: STAGES must be at least 1");
    end

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule : sync_ff_chain

// File: rtl/sync_gray_ptr.sv
// ----------------------------------------------------------------------------
// sync_gray_ptr
//   Brings a gray-coded FIFO pointer into the receiving clock domain and
//   derives registered status from consecutive synchronised samples.
//
//   Parameters:
//     ADDRSIZE    : FIFO address width; pointers are ADDRSIZE+1 bits
//                   (MSB is the wrap bit)
//     SYNC_STAGES : synchroniser depth, 2..4
//
//   Ports:
//     rclk        in   receiving-domain clock
//     rrst_n      in   asynchronous active-low reset; clears all state
//     wptr        in   ADDRSIZE+1  gray pointer from the source domain
//     err_clr     in   synchronous clear of gray_err
//     rq_wptr     out  ADDRSIZE+1  synchronised gray pointer
//     rq_wptr_bin out  ADDRSIZE+1  binary form of rq_wptr, one cycle later
//     ptr_adv     out  one-cycle pulse when the synchronised pointer moved
//     adv_cnt     out  ADDRSIZE+1  binary advance since previous sample
//                      (modulo 2^(ADDRSIZE+1))
//     gray_err    out  sticky: consecutive samples differed in >1 bit
//
//   Timing: rq_wptr lags wptr by SYNC_STAGES edges; all derived outputs lag
//   by SYNC_STAGES+1 edges. Outputs are valid every cycle, no handshake.
// ----------------------------------------------------------------------------
module sync_gray_ptr
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   wptr,
    input  logic                err_clr,
    output logic [ADDRSIZE:0]   rq_wptr,
    output logic [ADDRSIZE:0]   rq_wptr_bin,
    output logic                ptr_adv,
    output logic [ADDRSIZE:0]   adv_cnt,
    output logic                gray_err
);

    localparam int PTR_W = ADDRSIZE + 1;

    if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync_stages
        $error("sync_gray_ptr: SYNC_STAGES must be in the range 2..4");
    end

    if (PTR_W > MAX_PTR_W || ADDRSIZE < 1) begin : g_bad_addrsize
        $error("sync_gray_ptr: ADDRSIZE out of supported range");
    end

    // ---- synchroniser stages ------------------------------------------------
    logic [PTR_W-1:0] sync_q;

    sync_ff_chain #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk   (rclk),
        .rst_n (rrst_n),
        .d     (wptr),
        .q     (sync_q)
    );

    assign rq_wptr = sync_q;

    // ---- previous-sample register ------------------------------------------
    logic [PTR_W-1:0] prev_wptr_p0;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            prev_wptr_p0 <= '0;
        end else begin
            prev_wptr_p0 <= rq_wptr;
        end
    end

    // ---- derived status (combinational from rq_wptr / prev) ----------------
    logic [PTR_W-1:0] cur_bin;
    logic [PTR_W-1:0] prev_bin;
    logic [PTR_W-1:0] delta_bin;
    logic             changed;
    logic             multi_flip;

    always_comb begin
        cur_bin    = PTR_W'(gray2bin(ptr_word_t'(rq_wptr)));
        prev_bin   = PTR_W'(gray2bin(ptr_word_t'(prev_wptr_p0)));
        // Truncation to PTR_W makes the subtraction wrap-safe: a step from
        // the top pointer value back to zero reads as an advance of one.
        delta_bin  = cur_bin - prev_bin;
        changed    = (rq_wptr != prev_wptr_p0);
        multi_flip = (popcount(ptr_word_t'(rq_wptr ^ prev_wptr_p0)) > 1);
    end

    // ---- registered outputs -------------------------------------------------
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rq_wptr_bin <= '0;
            ptr_adv     <= 1'b0;
            adv_cnt     <= '0;
            gray_err    <= 1'b0;
        end else begin
            rq_wptr_bin <= cur_bin;
            ptr_adv     <= changed;
            adv_cnt     <= delta_bin;
            // A fresh violation wins over a coincident clear so it is never
            // silently lost.
            if (multi_flip) begin
                gray_err <= 1'b1;
            end else if (err_clr) begin
                gray_err <= 1'b0;
            end
        end
    end

endmodule : sync_gray_ptr

// File: tb/tb_sync_gray_ptr.sv
module tb_sync_gray_ptr;

    logic       rclk    = 1'b0;
    logic       rrst_n  = 1'b0;
    logic       err_clr = 1'b0;
    logic [4:0] wptr    = 5'd0;

    logic [4:0] rq2, bin2, cnt2;
    logic       adv2, err2;
    logic [4:0] rq3, bin3, cnt3;
    logic       adv3, err3;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [4:0] rq;
        logic [4:0] bin;
        logic       adv;
        logic [4:0] cnt;
        logic       err;
    } exp_t;

    exp_t sb[$];

    // reference model state for the 2-stage DUT
    logic [4:0] m_g   = 5'd0;
    logic       m_err = 1'b0;

    always #5 rclk = ~rclk;

    sync_gray_ptr #(.ADDRSIZE(4), .SYNC_STAGES(2)) dut2 (
        .rclk(rclk), .rrst_n(rrst_n), .wptr(wptr), .err_clr(err_clr),
        .rq_wptr(rq2), .rq_wptr_bin(bin2), .ptr_adv(adv2),
        .adv_cnt(cnt2), .gray_err(err2)
    );

    sync_gray_ptr #(.ADDRSIZE(4), .SYNC_STAGES(3)) dut3 (
        .rclk(rclk), .rrst_n(rrst_n), .wptr(wptr), .err_clr(err_clr),
        .rq_wptr(rq3), .rq_wptr_bin(bin3), .ptr_adv(adv3),
        .adv_cnt(cnt3), .gray_err(err3)
    );

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic int ones(input logic [4:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 5; i++) n += int'(v[i]);
        return n;
    endfunction

    // push the expected derived outputs for a move from m_g to g
    task automatic push_exp(input logic [4:0] g);
        exp_t e;
        e.rq  = g;
        e.bin = g2b(g);
        e.adv = (g != m_g);
        e.cnt = g2b(g) - g2b(m_g);
        e.err = m_err | (ones(g ^ m_g) > 1);
        sb.push_back(e);
        m_g   = g;
        m_err = e.err;
    endtask

    task automatic step_ptr(input logic [4:0] g, input logic clr_at_set, input string tag);
        exp_t e;
        push_exp(g);
        wptr = g;
        @(negedge rclk);
        total++;
        if (adv2 !== 1'b0 || cnt2 !== 5'd0) begin
            bad++;
            $display("FAIL %s_quiet: ptr_adv=%b adv_cnt=%0d, want 0/0", tag, adv2, cnt2);
        end
        @(negedge rclk);
        total++;
        if (rq2 !== g) begin
            bad++;
            $display("FAIL %s_rq: rq_wptr=%b want %b", tag, rq2, g);
        end
        if (clr_at_set) err_clr = 1'b1;
        @(negedge rclk);
        err_clr = 1'b0;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s_sb: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            if ({bin2, adv2, cnt2, err2} !== {e.bin, e.adv, e.cnt, e.err}) begin
                bad++;
                $display("FAIL %s_out: bin=%0d adv=%b cnt=%0d err=%b want bin=%0d adv=%b cnt=%0d err=%b",
                         tag, bin2, adv2, cnt2, err2, e.bin, e.adv, e.cnt, e.err);
            end
        end
    endtask

    task automatic pulse_clr(input string tag);
        @(negedge rclk);
        total++;
        if (err2 !== m_err) begin
            bad++;
            $display("FAIL %s_hold: gray_err=%b want %b", tag, err2, m_err);
        end
        err_clr = 1'b1;
        @(negedge rclk);
        err_clr = 1'b0;
        m_err   = 1'b0;
        total++;
        if (err2 !== 1'b0) begin
            bad++;
            $display("FAIL %s_clr: gray_err=%b want 0", tag, err2);
        end
    endtask

    task automatic test_reset();
        rrst_n = 1'b0;
        wptr   = 5'd0;
        #12;
        total++;
        if ({rq2, bin2, adv2, cnt2, err2} !== 17'd0) begin
            bad++;
            $display("FAIL reset_s2: outputs=%h want 0", {rq2, bin2, adv2, cnt2, err2});
        end
        total++;
        if ({rq3, bin3, adv3, cnt3, err3} !== 17'd0) begin
            bad++;
            $display("FAIL reset_s3: outputs=%h want 0", {rq3, bin3, adv3, cnt3, err3});
        end
        @(negedge rclk);
        rrst_n = 1'b1;
        repeat (4) @(negedge rclk);
        total++;
        if ({rq2, bin2, adv2, cnt2, err2} !== 17'd0) begin
            bad++;
            $display("FAIL release_s2: outputs=%h want 0", {rq2, bin2, adv2, cnt2, err2});
        end
        total++;
        if ({rq3, bin3, adv3, cnt3, err3} !== 17'd0) begin
            bad++;
            $display("FAIL release_s3: outputs=%h want 0", {rq3, bin3, adv3, cnt3, err3});
        end
    endtask

    task automatic test_first_step();
        step_ptr(5'b00001, 1'b0, "first");
    endtask

    task automatic test_stages3();
        exp_t e;
        logic [4:0] g;
        g = 5'b00011;
        e.rq = g; e.bin = 5'd2; e.adv = 1'b1; e.cnt = 5'd1; e.err = 1'b0;
        sb.push_back(e);
        wptr = g;
        @(negedge rclk);
        @(negedge rclk);
        total++;
        if (rq3 !== 5'b00001) begin
            bad++;
            $display("FAIL s3_early: rq_wptr=%b want 00001", rq3);
        end
        @(negedge rclk);
        total++;
        if (rq3 !== g || adv3 !== 1'b0) begin
            bad++;
            $display("FAIL s3_rq: rq_wptr=%b ptr_adv=%b want %b/0", rq3, adv3, g);
        end
        @(negedge rclk);
        e = sb.pop_front();
        total++;
        if ({bin3, adv3, cnt3, err3} !== {e.bin, e.adv, e.cnt, e.err}) begin
            bad++;
            $display("FAIL s3_out: bin=%0d adv=%b cnt=%0d err=%b want bin=%0d adv=%b cnt=%0d err=%b",
                     bin3, adv3, cnt3, err3, e.bin, e.adv, e.cnt, e.err);
        end
        m_g = g;
    endtask

    task automatic test_walk();
        for (int b = 3; b <= 32; b++) begin
            step_ptr(b2g(5'(b % 32)), 1'b0, "walk");
        end
        total++;
        if (err2 !== 1'b0) begin
            bad++;
            $display("FAIL walk_err: gray_err=%b want 0", err2);
        end
    endtask

    task automatic test_jump_err();
        step_ptr(5'b00011, 1'b0, "jump");
        pulse_clr("jump");
    endtask

    task automatic test_err_clr_priority();
        step_ptr(5'b01100, 1'b1, "prio");
        pulse_clr("prio");
    endtask

    task automatic test_mid_reset();
        exp_t e;
        wptr = 5'b01010;
        repeat (3) @(negedge rclk);
        #2 rrst_n = 1'b0;
        #1;
        total++;
        if ({rq2, bin2, adv2, cnt2, err2} !== 17'd0) begin
            bad++;
            $display("FAIL midrst_s2: outputs=%h want 0", {rq2, bin2, adv2, cnt2, err2});
        end
        total++;
        if ({rq3, bin3, adv3, cnt3, err3} !== 17'd0) begin
            bad++;
            $display("FAIL midrst_s3: outputs=%h want 0", {rq3, bin3, adv3, cnt3, err3});
        end
        @(negedge rclk);
        rrst_n = 1'b1;
        m_g   = 5'd0;
        m_err = 1'b0;
        push_exp(5'b01010);
        @(negedge rclk);
        @(negedge rclk);
        total++;
        if (rq2 !== 5'b01010) begin
            bad++;
            $display("FAIL midrst_rq: rq_wptr=%b want 01010", rq2);
        end
        @(negedge rclk);
        e = sb.pop_front();
        total++;
        if ({bin2, adv2, cnt2, err2} !== {e.bin, e.adv, e.cnt, e.err}) begin
            bad++;
            $display("FAIL midrst_out: bin=%0d adv=%b cnt=%0d err=%b want bin=%0d adv=%b cnt=%0d err=%b",
                     bin2, adv2, cnt2, err2, e.bin, e.adv, e.cnt, e.err);
        end
        total++;
        if (adv3 !== 1'b0) begin
            bad++;
            $display("FAIL midrst_s3_early: ptr_adv=%b want 0", adv3);
        end
        @(negedge rclk);
        total++;
        if ({bin3, adv3, cnt3, err3} !== {e.bin, e.adv, e.cnt, e.err}) begin
            bad++;
            $display("FAIL midrst_s3_out: bin=%0d adv=%b cnt=%0d err=%b want bin=%0d adv=%b cnt=%0d err=%b",
                     bin3, adv3, cnt3, err3, e.bin, e.adv, e.cnt, e.err);
        end
        total++;
        if (adv2 !== 1'b0) begin
            bad++;
            $display("FAIL midrst_pulse: ptr_adv=%b want 0", adv2);
        end
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_stages3();
        test_walk();
        test_jump_err();
        test_err_clr_priority();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sync_gray_ptr

// File: doc/sync_gray_ptr.md
Name: sync_gray_ptr

Overview:
- Parametrised N-stage synchroniser for a gray-coded FIFO pointer crossing into the receiving clock domain.
- Successor to the fixed 2-flop write-to-read pointer sync.
- Adds a configurable stage count, registered gray-to-binary conversion, a pointer-advance pulse, an advance-count delta, and a sticky gray-coding violation detector.
- Sits in the read (or write) domain of the async FIFO, between the pointer source and the full/empty logic.

Parameters:
- ADDRSIZE, 4, address width; pointers are ADDRSIZE+1 bits (MSB is the wrap bit).
- SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4; elaboration error outside this range.

Ports:
- rclk  input  1  receiving-domain clock; all state updates on the rising edge.
- rrst_n  input  1  asynchronous active-low reset for the receiving domain.
- wptr  input  ADDRSIZE+1  gray-coded pointer from the source domain, asynchronous to rclk.
- err_clr  input  1  synchronous clear of gray_err.
- rq_wptr  output  ADDRSIZE+1  synchronised gray pointer (last sync stage).
- rq_wptr_bin  output  ADDRSIZE+1  registered binary equivalent of rq_wptr.
- ptr_adv  output  1  single-cycle pulse: pointer changed since the previous cycle.
- adv_cnt  output  ADDRSIZE+1  binary delta (current minus previous), modulo 2^(ADDRSIZE+1).
- gray_err  output  1  sticky flag: more than one bit changed between consecutive synchronised samples.

Behaviour:
- Reset (rrst_n low, asynchronous):
  - Every sync stage, the previous-sample register, rq_wptr, rq_wptr_bin, adv_cnt, ptr_adv and gray_err go to 0 immediately.
  - Applies mid-operation too; no clock is required.
- Sync chain: stage[0] <= wptr; stage[i] <= stage[i-1]; rq_wptr = stage[SYNC_STAGES-1].
- Latency:
  - A stable wptr change appears on rq_wptr SYNC_STAGES rising edges after the first edge that samples it.
  - Derived outputs (rq_wptr_bin, ptr_adv, adv_cnt, gray_err) follow one edge later, i.e. SYNC_STAGES+1.
- Previous-sample register prev <= rq_wptr each edge (reset 0).
- Derived logic, registered each edge from rq_wptr and prev:
  - rq_wptr_bin <= gray2bin(rq_wptr).
  - ptr_adv <= (rq_wptr != prev).
  - adv_cnt <= gray2bin(rq_wptr) - gray2bin(prev), truncated to ADDRSIZE+1 bits (wrap-safe modulo arithmetic); 0 when unchanged.
  - gray_err set condition: popcount(rq_wptr ^ prev) > 1.
- gray_err update:
  - Set has priority over err_clr in the same cycle; the flag stays 1.
  - err_clr alone clears it on the next edge.
  - Otherwise it holds.
- Wrap-around: gray 10000 -> 00000 (bin 31 -> 0, ADDRSIZE=4) is a legal single-bit change: adv_cnt=1, no error.
- Immediately after reset release, with wptr=0: no ptr_adv, adv_cnt=0, no error.
- No handshake. The consumer treats rq_wptr_bin and adv_cnt as valid every cycle; ptr_adv qualifies a change.
- Metastability: stage[0] is the only flop sampling wptr. No logic between sync stages.

Decomposition:
- Shared package fifo_pkg:
  - function gray2bin (parametrised by width via ADDRSIZE).
  - function bin2gray.
  - function popcount.
  - constants MIN_SYNC_STAGES=2, MAX_SYNC_STAGES=4.
- One natural sub-module: sync_ff_chain (WIDTH, STAGES; clock, async active-low reset, d, q). It is instantiated once for the pointer and is reusable for single-bit control syncs.

Test Plan:
- ADDRSIZE=4, SYNC_STAGES=2; wptr 00000 -> 00001 held, sampled at edge k -> rq_wptr=00001 after edge k+1; at edge k+2 rq_wptr_bin=1, ptr_adv=1 for one cycle, adv_cnt=1, gray_err=0.
- Walk the full gray sequence bin 0..31 then wrap to 0, one step per 3 cycles -> rq_wptr_bin tracks 0..31,0; at the 10000 -> 00000 step adv_cnt=1, gray_err never set.
- Jump wptr 00000 -> 00011 (bin 2) in one step -> gray_err=1 at edge k+2, adv_cnt=2; err_clr pulsed alone later -> gray_err=0 next edge.
- Error with err_clr asserted in the same cycle as the set condition (00011 -> 01100) -> gray_err remains 1; clear on a later quiet cycle -> 0.
- SYNC_STAGES=3; wptr 00000 -> 00001 -> rq_wptr updates after the third edge, ptr_adv after the fourth; SYNC_STAGES=1 -> elaboration error.
- Drive wptr=01010, then assert rrst_n low between edges -> all outputs 0 without a clock edge; release with wptr=01010 -> after SYNC_STAGES+1 edges ptr_adv=1, rq_wptr_bin=12, adv_cnt=12, gray_err=1 (popcount 2).
